// File: rtl/sfp_pkg.sv
// sfp_pkg: shared PRBS-31 definitions for the SFP transmit generator and receive checker
package sfp_pkg;

    typedef enum logic [1:0] {IDLE, SEED, VERIFY, LOCKED} prbs_state_t;

    localparam int PRBS_TAP_A = 31;
    localparam int PRBS_TAP_B = 28;
    localparam int PRBS_MAX_W = 64;

    // Returns {word, next_state}. The word is right-justified in PRBS_MAX_W bits:
    // the first generated bit lands at bit width-1 and the bits above width stay zero.
    function automatic logic [PRBS_MAX_W+30:0] prbs31_next_word(input logic [30:0] state, input int width);
        logic [30:0]           s;
        logic [PRBS_MAX_W-1:0] w;
        logic                  b;
        s = state;
        w = '0;
        for (int i = 0; i < PRBS_MAX_W; i++) begin
            if (i < width) begin
                b = s[PRBS_TAP_A-1] ^ s[PRBS_TAP_B-1];
                w = {w[PRBS_MAX_W-2:0], b};
                s = {s[29:0], b};
            end
        end
        return {w, s};
    endfunction

endpackage

// File: rtl/sfp_prbs_checker_popcount_tree.sv
// popcount_tree: combinational count of set bits in a word
module popcount_tree #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [CNT_W-1:0]  o_count
);

    // Sum every bit; synthesis balances the adder chain into a tree
    always_comb begin
        o_count = '0;
        for (int i = 0; i < DATA_W; i++) o_count = o_count + CNT_W'(i_data[i]);
    end

endmodule

// File: rtl/sfp_prbs_checker.sv
// sfp_prbs_checker: self-seeding PRBS-31 receive checker with lock FSM and error counters
module sfp_prbs_checker
    import sfp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              sfp_sgd,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              err_word,
    output logic [31:0]       bit_err_cnt,
    output logic [47:0]       word_cnt
);

    localparam int PW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    prbs_state_t           r_state, w_state_nxt;
    logic [30:0]           r_lfsr, w_lfsr_nxt, w_lfsr_adv;
    logic [GW-1:0]         r_good, w_good_nxt;
    logic [BW-1:0]         r_bad, w_bad_nxt;
    logic                  r_locked, r_err_word;
    logic [31:0]           r_bit_err_cnt;
    logic [47:0]           r_word_cnt;
    logic [PRBS_MAX_W+30:0] w_pred;
    logic [PRBS_MAX_W-1:0] w_exp, w_mis;
    logic [PW-1:0]         w_pop;
    logic [32:0]           w_sum;
    logic                  w_miss, w_chk;

    // Expected word is zero above DATA_W, so the full-width compare only sees real bits
    assign w_pred          = prbs31_next_word(r_lfsr, DATA_W);
    assign {w_exp, w_lfsr_adv} = w_pred;
    assign w_mis           = PRBS_MAX_W'(rx_data) ^ w_exp;
    assign w_miss          = |w_mis;
    assign w_chk           = sfp_sgd & rx_valid & (r_state == LOCKED);
    assign w_sum           = {1'b0, r_bit_err_cnt} + 33'(w_pop);

    popcount_tree #(.DATA_W(DATA_W)) u_popcount (
        .i_data  (w_mis[DATA_W-1:0]),
        .o_count (w_pop)
    );

    // Next-state: signal loss forces IDLE; otherwise only valid words advance the FSM and LFSR
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        if (!sfp_sgd) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = SEED;
                SEED: if (rx_valid) begin
                    w_lfsr_nxt  = rx_data[30:0];
                    w_good_nxt  = '0;
                    w_state_nxt = VERIFY;
                end
                VERIFY: if (rx_valid) begin
                    w_lfsr_nxt = w_lfsr_adv;
                    if (w_miss) begin
                        w_state_nxt = SEED;
                    end else if (r_good == GW'(LOCK_CNT - 1)) begin
                        w_state_nxt = LOCKED;
                        w_bad_nxt   = '0;
                    end else begin
                        w_good_nxt = r_good + GW'(1);
                    end
                end
                LOCKED: if (rx_valid) begin
                    w_lfsr_nxt = w_lfsr_adv;
                    if (!w_miss) w_bad_nxt = '0;
                    else if (r_bad == BW'(UNLOCK_CNT - 1)) w_state_nxt = SEED;
                    else w_bad_nxt = r_bad + BW'(1);
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM, LFSR and good/bad run registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_lfsr  <= '0;
            r_good  <= '0;
            r_bad   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_good  <= w_good_nxt;
            r_bad   <= w_bad_nxt;
        end
    end

    // Registered status and counters; clear_cnt takes priority over an increment
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_locked      <= 1'b0;
            r_err_word    <= 1'b0;
            r_bit_err_cnt <= '0;
            r_word_cnt    <= '0;
        end else begin
            r_locked   <= (w_state_nxt == LOCKED);
            r_err_word <= w_chk & w_miss;
            if (clear_cnt) begin
                r_bit_err_cnt <= '0;
                r_word_cnt    <= '0;
            end else if (w_chk) begin
                r_word_cnt    <= r_word_cnt + 48'd1;
                r_bit_err_cnt <= w_sum[32] ? '1 : w_sum[31:0];
            end
        end
    end

    assign locked      = r_locked;
    assign err_word    = r_err_word;
    assign bit_err_cnt = r_bit_err_cnt;
    assign word_cnt    = r_word_cnt;

endmodule
